imem_loader: RTL
================

# imem_loader

Boot-time instruction-memory loader for the pipelined RISC-V processor. It receives a program image over a byte-wide valid/ready stream, assembles little-endian 32-bit words, and writes them into instruction memory at consecutive byte addresses starting at 0. It holds the processor in reset until the image is loaded and its checksum verifies. It replaces preloading instruction memory from a file, so the same program image can be delivered by a bench or a host link.

## Interface
- MEM_BYTES, 512: instruction memory size in bytes. Maximum image length is MEM_BYTES/4 words.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  a byte is offered on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle. A byte transfers when in_valid & in_ready at a rising edge.
- im_we  output  1  instruction-memory write strobe, one cycle per word.
- im_addr  output  32  byte address of the word being written (multiple of 4).
- im_wdata  output  32  word being written.
- cpu_reset  output  1  active-high reset to the processor. Deasserted only in DONE.
- done  output  1  image loaded and checksum matched.
- error  output  1  length too large or checksum mismatch.

## Operation
- Stream format:
  - LEN_LO, LEN_HI: 16-bit word count N, little-endian.
  - N×4 data bytes: each word's bits 7:0 come first.
  - CHK: XOR of all data bytes, with an initial value of 0x00.
- States:
  - LEN0: accept LEN_LO, go to LEN1.
  - LEN1: accept LEN_HI. If N > MEM_BYTES/4, go to ERR. If N == 0, go to CHK. Otherwise go to DATA.
  - DATA: accept a byte into lane byte_idx, update the running XOR, and increment byte_idx (2 bits, wraps). When the accepted byte has byte_idx == 3, go to WRITE.
  - WRITE: im_we = 1 for exactly one cycle with im_addr = word_cnt×4 and im_wdata = the assembled word. Then increment word_cnt. If word_cnt + 1 == N, go to CHK; else go to DATA.
  - CHK: accept one byte. If it equals the running XOR, go to DONE; else go to ERR.
  - DONE: terminal until reset. cpu_reset = 0, done = 1, in_ready = 0.
  - ERR: terminal until reset. cpu_reset = 1, error = 1, in_ready = 0.
- in_ready is 1 only in LEN0, LEN1, DATA and CHK, and is forced to 0 while reset is low.
- Outside WRITE, im_addr and im_wdata hold their last values; only im_we qualifies them.
- Widths:
  - word_cnt is 16 bits.
  - im_addr is zero-extended {word_cnt, 2'b00}.
  - The length compare uses the full 16-bit N. For example, 0xFFFF with MEM_BYTES = 512 is rejected.
- Words already written before an ERR are not undone. cpu_reset remains asserted.

## Timing
- Reset values: state LEN0, in_ready 0 (gated by reset), im_we 0, im_addr 0, im_wdata 0, cpu_reset 1, done 0, error 0, byte_idx 0, word_cnt 0, XOR 0.
- Reset assertion is asynchronous at any time, including mid-DATA or mid-WRITE: all state returns to reset values and a partially assembled word is discarded. A new load always restarts with LEN0 and address 0.
- in_ready rises the first clock after reset is released.
- The byte accepted at the edge ending DATA with byte_idx 3 produces im_we = 1 in the following cycle. in_ready is 0 in that cycle, so a held in_valid byte is not lost.
- Minimum load time: 2 + 5N + 1 cycles, with in_valid held high.
- cpu_reset falls, and done rises, on the same edge that enters DONE. error rises on the edge that enters ERR.
- in_valid gaps stall the FSM in its current state with no side effects.

## Test plan
- Stream 02 00 | 13 05 50 00 | 93 05 A0 00 | 70:
  - writes (addr 0, 0x00500513) and (addr 4, 0x00A00593), each with im_we high for one cycle;
  - done = 1, cpu_reset = 0, error = 0;
  - total of 13 cycles from the first accept.
- Stream 00 00 | 00: no im_we pulse; done = 1 and cpu_reset = 0 after 3 accepted bytes.
- Stream 81 00 with MEM_BYTES = 512: error = 1 on the edge after LEN_HI; in_ready = 0; cpu_reset stays 1; later bytes are ignored.
- Same stream as the first scenario but CHK = 71: both words are written, then error = 1, done = 0, cpu_reset = 1.
- First-scenario stream with in_valid pseudo-randomly deasserted about 50% of cycles: identical writes and final outputs; in_ready is low in every WRITE cycle and no byte is dropped or duplicated.
- Reset pulsed low after 3 of the first 4 data bytes, then the full first-scenario stream resent: outputs return to reset values immediately; the first write after reload goes to addr 0 with 0x00500513.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: takes a length-prefixed, XOR-checksummed
// byte stream, writes little-endian words from address 0 and then releases the CPU.
module imem_loader #(
  parameter int MEM_BYTES = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'(MEM_BYTES / 4);

  state_t      state_q, state_d;
  logic        ready_en_q;
  logic [7:0]  len_lo_q;
  logic [15:0] len_q;
  logic [1:0]  byte_idx_q;
  logic [15:0] word_cnt_q;
  logic [7:0]  chk_q;
  logic [23:0] asm_q;
  logic [31:0] im_addr_q;
  logic [31:0] im_wdata_q;

  logic        accept;
  logic [15:0] length_n;
  logic        last_word;

  assign accept    = in_valid && in_ready;
  assign length_n  = {in_data, len_lo_q};
  assign last_word = (word_cnt_q + 16'd1) == len_q;

  // Outputs are decoded from the state register, so done/cpu_reset/error
  // change on the very edge that enters the terminal state.
  // NOTE: every signal driven in always_comb gets a default first, otherwise a
  // path that skips the assignment infers a latch.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    im_we     = 1'b0;
    cpu_reset = 1'b1;
    done      = 1'b0;
    error     = 1'b0;

    case (state_q)
      S_LEN0: begin
        in_ready = ready_en_q;
        if (accept) state_d = S_LEN1;
      end
      S_LEN1: begin
        in_ready = ready_en_q;
        if (accept) begin
          if ({1'b0, length_n} > MAX_WORDS) state_d = S_ERR;
          else if (length_n == 16'd0)       state_d = S_CHK;
          else                              state_d = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = ready_en_q;
        if (accept && byte_idx_q == 2'd3) state_d = S_WRITE;
      end
      S_WRITE: begin
        im_we   = 1'b1;
        state_d = last_word ? S_CHK : S_DATA;
      end
      S_CHK: begin
        in_ready = ready_en_q;
        if (accept) state_d = (in_data == chk_q) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
      end
      S_ERR: begin
        error = 1'b1;
      end
      default: state_d = S_ERR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_LEN0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
    end
  end

  // Datapath: the word is assembled in asm_q and committed to the output
  // registers on the fourth byte, so im_addr/im_wdata are stable through WRITE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_lo_q   <= '0;
      len_q      <= '0;
      byte_idx_q <= '0;
      word_cnt_q <= '0;
      chk_q      <= '0;
      asm_q      <= '0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
    end else begin
      case (state_q)
        S_LEN0: if (accept) len_lo_q <= in_data;
        S_LEN1: if (accept) len_q <= length_n;
        S_DATA: begin
          if (accept) begin
            chk_q      <= chk_q ^ in_data;
            byte_idx_q <= byte_idx_q + 2'd1;
            case (byte_idx_q)
              2'd0: asm_q[7:0]   <= in_data;
              2'd1: asm_q[15:8]  <= in_data;
              2'd2: asm_q[23:16] <= in_data;
              default: begin
                im_wdata_q <= {in_data, asm_q};
                im_addr_q  <= {14'd0, word_cnt_q, 2'b00};
              end
            endcase
          end
        end
        S_WRITE: word_cnt_q <= word_cnt_q + 16'd1;
        default: ;
      endcase
    end
  end

  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;

endmodule
